nn_argmax_classifier: RTL and testbench



---
 rtl/nn_argmax_classifier_pkg.sv | 25 ++
 rtl/nn_argmax_classifier_if.sv | 58 +++++
 rtl/nn_argmax_classifier_argmax_update.sv | 40 ++++
 rtl/nn_argmax_classifier.sv | 162 ++++++++++++++++
 tb/tb_nn_argmax_classifier.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/nn_argmax_classifier_pkg.sv
// ============================================================================
// Module      : nn_pkg
// Description : Shared constants and FSM encoding for the vfr_nn argmax stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package nn_pkg;

    localparam int NN_WIDTH       = 16;
    localparam int NN_FRAC        = 8;
    localparam int NN_NUM_CLASSES = 10;
    localparam int NN_IDX_W       = 4;

    localparam logic signed [NN_WIDTH-1:0] MIN_SCORE = {1'b1, {(NN_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/nn_argmax_classifier_if.sv
// ============================================================================
// Module      : nn_argmax_classifier_if
// Description : Score-set input and result output handshakes of the argmax
//               classifier. Optional reject flag under ARGMAX_THRESH_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface nn_argmax_classifier_if
    import nn_pkg::*;
#(
    parameter int WIDTH = NN_WIDTH,
    parameter int IDX_W = NN_IDX_W
);
    logic                    in_valid;
    logic                    in_ready;
    logic signed [WIDTH-1:0] net_output1;
    logic signed [WIDTH-1:0] net_output2;
    logic signed [WIDTH-1:0] net_output3;
    logic signed [WIDTH-1:0] net_output4;
    logic signed [WIDTH-1:0] net_output5;
    logic signed [WIDTH-1:0] net_output6;
    logic signed [WIDTH-1:0] net_output7;
    logic signed [WIDTH-1:0] net_output8;
    logic signed [WIDTH-1:0] net_output9;
    logic signed [WIDTH-1:0] net_output10;
    logic                    out_valid;
    logic                    out_ready;
    logic [IDX_W-1:0]        class_idx;
    logic signed [WIDTH-1:0] max_score;
    logic [WIDTH-1:0]        margin;
`ifdef ARGMAX_THRESH_EN
    logic                    reject;
`endif

    modport master (
        output in_valid, net_output1, net_output2, net_output3, net_output4,
               net_output5, net_output6, net_output7, net_output8,
               net_output9, net_output10, out_ready,
        input  in_ready, out_valid, class_idx, max_score, margin
`ifdef ARGMAX_THRESH_EN
        , input reject
`endif
    );

    modport slave (
        input  in_valid, net_output1, net_output2, net_output3, net_output4,
               net_output5, net_output6, net_output7, net_output8,
               net_output9, net_output10, out_ready,
        output in_ready, out_valid, class_idx, max_score, margin
`ifdef ARGMAX_THRESH_EN
        , output reject
`endif
    );

endinterface

`default_nettype wire

// File: rtl/nn_argmax_classifier_argmax_update.sv
// ============================================================================
// Module      : argmax_update
// Description : One running top-2 compare step (signed, lowest index wins ties).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module argmax_update
    import nn_pkg::*;
#(
    parameter int WIDTH = NN_WIDTH,
    parameter int IDX_W = NN_IDX_W
) (
    input  wire logic signed [WIDTH-1:0] s,
    input  wire logic [IDX_W-1:0]        cnt,
    input  wire logic signed [WIDTH-1:0] best,
    input  wire logic signed [WIDTH-1:0] second,
    input  wire logic [IDX_W-1:0]        idx,
    output logic signed [WIDTH-1:0]      best_nxt,
    output logic signed [WIDTH-1:0]      second_nxt,
    output logic [IDX_W-1:0]             idx_nxt
);

    always_comb begin
        best_nxt   = best;
        second_nxt = second;
        idx_nxt    = idx;
        if (s > best) begin
            second_nxt = best;
            best_nxt   = s;
            idx_nxt    = cnt;
        end else if (s > second) begin
            // A score equal to best lands here, which yields a zero margin.
            second_nxt = s;
        end
    end

endmodule

`default_nettype wire

// File: rtl/nn_argmax_classifier.sv
// ============================================================================
// Module      : nn_argmax_classifier
// Description : Captures ten signed scores, scans them one per cycle and
//               reports the winning class, score and margin over runner-up.
//               Optional margin-threshold reject flag: ARGMAX_THRESH_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module nn_argmax_classifier
    import nn_pkg::*;
#(
    parameter int WIDTH       = NN_WIDTH,
    parameter int FRAC        = NN_FRAC,
    parameter int NUM_CLASSES = NN_NUM_CLASSES,
    parameter int IDX_W       = NN_IDX_W
`ifdef ARGMAX_THRESH_EN
    ,
    parameter logic signed [WIDTH-1:0] THRESH = WIDTH'(16'sh0080)
`endif
) (
    input  wire logic              clk,
    input  wire logic              rst,
    nn_argmax_classifier_if.slave  bus
);

    localparam logic signed [WIDTH-1:0] c_min_score = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [IDX_W-1:0]        c_last_idx  = IDX_W'(NUM_CLASSES - 1);

    // FRAC only describes the fixed-point format; arithmetic is scale-free.
    if (FRAC >= WIDTH) begin : g_frac_guard
    end

    state_t                  r_state;
    logic signed [WIDTH-1:0] r_score [NUM_CLASSES];
    logic [IDX_W-1:0]        r_cnt;
    logic [IDX_W-1:0]        r_idx;
    logic signed [WIDTH-1:0] r_best;
    logic signed [WIDTH-1:0] r_second;
    logic                    r_in_ready;
    logic                    r_out_valid;
    logic [IDX_W-1:0]        r_class_idx;
    logic signed [WIDTH-1:0] r_max_score;
    logic [WIDTH-1:0]        r_margin;

    logic signed [WIDTH-1:0] w_s;
    logic signed [WIDTH-1:0] w_best_nxt;
    logic signed [WIDTH-1:0] w_second_nxt;
    logic [IDX_W-1:0]        w_idx_nxt;
    logic signed [WIDTH:0]   w_margin_full;

    assign w_s = r_score[r_cnt];

    argmax_update #(
        .WIDTH (WIDTH),
        .IDX_W (IDX_W)
    ) u_update (
        .s          (w_s),
        .cnt        (r_cnt),
        .best       (r_best),
        .second     (r_second),
        .idx        (r_idx),
        .best_nxt   (w_best_nxt),
        .second_nxt (w_second_nxt),
        .idx_nxt    (w_idx_nxt)
    );

    // One extra bit so best - second never wraps; the result is always >= 0.
    assign w_margin_full = {w_best_nxt[WIDTH-1], w_best_nxt}
                         - {w_second_nxt[WIDTH-1], w_second_nxt};

`ifdef ARGMAX_THRESH_EN
    localparam logic signed [WIDTH:0] c_thresh = {THRESH[WIDTH-1], THRESH};
    logic r_reject;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_idx       <= '0;
            r_best      <= '0;
            r_second    <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_class_idx <= '0;
            r_max_score <= '0;
            r_margin    <= '0;
            for (int i = 0; i < NUM_CLASSES; i++) begin
                r_score[i] <= '0;
            end
`ifdef ARGMAX_THRESH_EN
            r_reject    <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.in_valid) begin
                        r_score[0] <= bus.net_output1;
                        r_score[1] <= bus.net_output2;
                        r_score[2] <= bus.net_output3;
                        r_score[3] <= bus.net_output4;
                        r_score[4] <= bus.net_output5;
                        r_score[5] <= bus.net_output6;
                        r_score[6] <= bus.net_output7;
                        r_score[7] <= bus.net_output8;
                        r_score[8] <= bus.net_output9;
                        r_score[9] <= bus.net_output10;
                        r_best     <= bus.net_output1;
                        r_idx      <= '0;
                        r_second   <= c_min_score;
                        r_cnt      <= IDX_W'(1);
                        r_in_ready <= 1'b0;
                        r_state    <= SCAN;
                    end
                end
                SCAN: begin
                    r_best   <= w_best_nxt;
                    r_second <= w_second_nxt;
                    r_idx    <= w_idx_nxt;
                    if (r_cnt == c_last_idx) begin
                        r_cnt       <= '0;
                        r_class_idx <= w_idx_nxt;
                        r_max_score <= w_best_nxt;
                        r_margin    <= w_margin_full[WIDTH-1:0];
`ifdef ARGMAX_THRESH_EN
                        r_reject    <= (w_margin_full < c_thresh);
`endif
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end else begin
                        r_cnt <= r_cnt + IDX_W'(1);
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.class_idx = r_class_idx;
    assign bus.max_score = r_max_score;
    assign bus.margin    = r_margin;
`ifdef ARGMAX_THRESH_EN
    assign bus.reject    = r_reject;
`endif

endmodule

`default_nettype wire

// File: tb/tb_nn_argmax_classifier.sv
// ============================================================================
// Module      : tb_nn_argmax_classifier
// Description : Directed and random score sets against a top-2 reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_nn_argmax_classifier;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    nn_argmax_classifier_if #(.WIDTH(16), .IDX_W(4)) bus ();

    nn_argmax_classifier dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    logic signed [15:0] cur [10];
    int                 exp_idx;
    logic signed [15:0] exp_max;
    logic [15:0]        exp_margin;
    logic               exp_rej;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Winner = first index holding the maximum; runner-up = max of the rest.
    task automatic model();
        int best;
        int second;
        best    = int'(cur[0]);
        exp_idx = 0;
        for (int i = 1; i < 10; i++) begin
            if (int'(cur[i]) > best) begin
                best    = int'(cur[i]);
                exp_idx = i;
            end
        end
        second = -32768;
        for (int i = 0; i < 10; i++) begin
            if (i != exp_idx && int'(cur[i]) > second) second = int'(cur[i]);
        end
        exp_max    = 16'(best);
        exp_margin = 16'(best - second);
        exp_rej    = (best - second) < 128;
    endtask

    task automatic drive_scores();
        bus.net_output1  = cur[0];
        bus.net_output2  = cur[1];
        bus.net_output3  = cur[2];
        bus.net_output4  = cur[3];
        bus.net_output5  = cur[4];
        bus.net_output6  = cur[5];
        bus.net_output7  = cur[6];
        bus.net_output8  = cur[7];
        bus.net_output9  = cur[8];
        bus.net_output10 = cur[9];
    endtask

    task automatic drive_junk();
        bus.net_output1  = 16'($urandom);
        bus.net_output2  = 16'($urandom);
        bus.net_output3  = 16'($urandom);
        bus.net_output4  = 16'($urandom);
        bus.net_output5  = 16'($urandom);
        bus.net_output6  = 16'($urandom);
        bus.net_output7  = 16'($urandom);
        bus.net_output8  = 16'($urandom);
        bus.net_output9  = 16'($urandom);
        bus.net_output10 = 16'($urandom);
    endtask

    task automatic check_result(input string tag);
        check({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
        check({tag, "_idx"}, 32'(bus.class_idx), 32'(exp_idx));
        check({tag, "_max"}, 32'(bus.max_score), 32'(exp_max));
        check({tag, "_margin"}, 32'(bus.margin), 32'(exp_margin));
`ifdef ARGMAX_THRESH_EN
        check({tag, "_reject"}, 32'(bus.reject), 32'(exp_rej));
`endif
    endtask

    // Accept one set, measure latency, optionally stall in DONE, then drain.
    task automatic run_set(input string tag, input bit disturb, input int hold);
        int lat;
        model();
        drive_scores();
        bus.in_valid = 1'b1;
        check({tag, "_in_ready_idle"}, 32'(bus.in_ready), 32'd1);
        step();
        bus.in_valid = 1'b0;
        check({tag, "_in_ready_scan"}, 32'(bus.in_ready), 32'd0);
        lat = 1;
        while (!bus.out_valid && lat < 40) begin
            if (disturb) begin
                drive_junk();
                bus.in_valid = 1'b1;
            end
            step();
            lat++;
        end
        bus.in_valid = 1'b0;
        check({tag, "_latency"}, 32'(lat), 32'd10);
        check_result(tag);
        for (int h = 0; h < hold; h++) begin
            drive_junk();
            bus.in_valid = 1'b1;
            step();
            check({tag, "_hold_in_ready"}, 32'(bus.in_ready), 32'd0);
            check_result({tag, "_hold"});
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        check({tag, "_drain_valid"}, 32'(bus.out_valid), 32'd0);
        check({tag, "_drain_in_ready"}, 32'(bus.in_ready), 32'd1);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
        check({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
        check({tag, "_idx"}, 32'(bus.class_idx), 32'd0);
        check({tag, "_max"}, 32'(bus.max_score), 32'd0);
        check({tag, "_margin"}, 32'(bus.margin), 32'd0);
`ifdef ARGMAX_THRESH_EN
        check({tag, "_reject"}, 32'(bus.reject), 32'd0);
`endif
    endtask

    initial begin
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        for (int i = 0; i < 10; i++) cur[i] = '0;
        drive_scores();
        step();
        step();
        check_reset_state("reset");
        rst = 1'b0;
        step();

        // Single clear winner
        for (int i = 0; i < 10; i++) cur[i] = 16'shFE00;
        cur[6] = 16'sh0180;
        run_set("winner6", 1'b0, 0);
        check("winner6_margin_const", 32'(exp_margin), 32'h0380);

        // Ties keep the lowest index
        for (int i = 0; i < 10; i++) cur[i] = 16'sh0000;
        cur[2] = 16'sh0100;
        cur[7] = 16'sh0100;
        run_set("tie27", 1'b0, 0);

        for (int i = 0; i < 10; i++) cur[i] = 16'sh8000;
        run_set("all_min", 1'b0, 0);

        // Full-range margin
        for (int i = 0; i < 10; i++) cur[i] = 16'sh8000;
        cur[9] = 16'sh7FFF;
        run_set("extreme", 1'b0, 0);

        // Backpressure in DONE with new offers ignored
        for (int i = 0; i < 10; i++) cur[i] = 16'(i * 37 - 100);
        run_set("backpressure", 1'b0, 5);

        // Input churn and in_valid during SCAN
        for (int i = 0; i < 10; i++) cur[i] = 16'($urandom);
        run_set("disturb", 1'b1, 0);

        // Reset in the 4th SCAN cycle discards the set
        for (int i = 0; i < 10; i++) cur[i] = 16'($urandom);
        drive_scores();
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        step();
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_reset_state("midscan_rst");
        for (int i = 0; i < 10; i++) cur[i] = 16'($urandom);
        run_set("after_rst", 1'b0, 0);

`ifdef ARGMAX_THRESH_EN
        for (int i = 0; i < 10; i++) cur[i] = 16'sh0000;
        cur[3] = 16'sh0140;
        cur[5] = 16'sh0100;
        run_set("thresh_low", 1'b0, 0);
        check("thresh_low_rej_const", 32'(exp_rej), 32'd1);
`endif

        // Random sets; half drawn from a tiny range to force ties
        for (int n = 0; n < 12; n++) begin
            for (int i = 0; i < 10; i++) begin
                if (n % 2 == 0) cur[i] = 16'($urandom);
                else cur[i] = 16'(int'($urandom_range(0, 3)) - 1);
            end
            run_set("random", 1'b0, n % 3);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
